// File: rtl/prog_loader.sv
// Boot loader: assembles a big-endian word stream into instruction memory,
// verifies an XOR checksum and releases the core only after a clean load.
module prog_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              restart,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_run,
  output logic              load_done,
  output logic              load_err
);

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
    CSUM,
    RUN,
    ERR
  } state_t;

  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  state_t state;
  state_t state_nx;

  logic [7:0]    n_hi;
  logic [15:0]   n_words;
  logic [1:0]    bcnt;
  logic [ADDR_W:0] widx;
  logic [7:0]    csum;
  logic [23:0]   asm_q;

  logic          take;
  logic [16:0]   n_hdr;
  logic [16:0]   widx_inc;
  logic [31:0]   word_nx;
  logic          last_byte;
  logic          last_word;
  logic          csum_ok;
  logic          clr;

  assign take      = in_valid && in_ready;
  assign n_hdr     = {1'b0, n_hi, in_data};
  assign widx_inc  = 17'(widx) + 17'd1;
  assign word_nx   = {asm_q, in_data};
  assign last_byte = bcnt == 2'd3;
  assign last_word = widx_inc == {1'b0, n_words};
  assign csum_ok   = in_data == csum;
  assign clr       = restart && (state == RUN || state == ERR);

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      state <= HDR_HI;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    cpu_run  = 1'b0;
    load_err = 1'b0;
    unique case (state)
      HDR_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = HDR_LO;
      end
      HDR_LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (n_hdr > CAP)          state_nx = ERR;
          else if (n_hdr == 17'd0)  state_nx = CSUM;
          else                      state_nx = DATA;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        if (in_valid && last_byte && last_word) state_nx = CSUM;
      end
      CSUM: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = csum_ok ? RUN : ERR;
      end
      RUN: begin
        cpu_run = 1'b1;
        if (restart) state_nx = HDR_HI;
      end
      ERR: begin
        load_err = 1'b1;
        if (restart) state_nx = HDR_HI;
      end
      default: state_nx = HDR_HI;
    endcase
  end

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      n_hi      <= '0;
      n_words   <= '0;
      bcnt      <= '0;
      widx      <= '0;
      csum      <= '0;
      asm_q     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      load_done <= 1'b0;
    end else begin
      mem_we    <= 1'b0;
      load_done <= 1'b0;
      if (clr) begin
        bcnt  <= '0;
        widx  <= '0;
        csum  <= '0;
        asm_q <= '0;
      end
      if (take) begin
        case (state)
          HDR_HI: n_hi <= in_data;
          HDR_LO: n_words <= {n_hi, in_data};
          DATA: begin
            asm_q <= word_nx[23:0];
            csum  <= csum ^ in_data;
            bcnt  <= bcnt + 2'd1;
            // word complete: present it to memory next cycle
            if (last_byte) begin
              mem_we    <= 1'b1;
              mem_addr  <= widx[ADDR_W-1:0];
              mem_wdata <= word_nx;
              widx      <= widx + 1'b1;
            end
          end
          CSUM: load_done <= csum_ok;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomised directed bench for prog_loader against a stream-level model
// that derives writes and outcome directly from the byte stream.
module tb_prog_loader;

  typedef logic [7:0] bq_t[$];

  logic        clk1;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        restart;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_run;
  logic        load_done;
  logic        load_err;

  int total = 0;
  int bad   = 0;

  prog_loader #(.ADDR_W(10)) dut (
    .clk1      (clk1),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .restart   (restart),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_run   (cpu_run),
    .load_done (load_done),
    .load_err  (load_err)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bq_t make_stream(input int n, input bit bad_sum);
    bq_t s;
    logic [7:0] x;
    logic [7:0] b;
    s = {};
    x = 8'h00;
    s.push_back(8'(n >> 8));
    s.push_back(8'(n));
    for (int k = 0; k < 4 * n; k++) begin
      b = 8'($urandom);
      x ^= b;
      s.push_back(b);
    end
    s.push_back(bad_sum ? ~x : x);
    return s;
  endfunction

  task automatic send(input bq_t s, input int gap, input bit hold_rs,
                      input int stop_at);
    int n, nb, i, cyc, spur, lim, want;
    bit hdr_err, pend, v;
    logic [7:0]  x;
    logic [31:0] pa, pw;
    n = int'({s[0], s[1]});
    hdr_err = n > 1024;
    nb = hdr_err ? 2 : 2 + 4 * n + 1;
    x = 8'h00;
    if (!hdr_err)
      for (int k = 2; k < 2 + 4 * n; k++) x ^= s[k];
    want = stop_at < nb ? stop_at : nb;
    lim = 20 * nb + 100;
    i = 0; cyc = 0; spur = 0; pend = 1'b0; pa = 0; pw = 0;
    while (i < want && cyc < lim) begin
      @(negedge clk1);
      if (pend) begin
        chk("we", 32'(mem_we), 32'd1);
        chk("addr", 32'(mem_addr), pa);
        chk("wdata", mem_wdata, pw);
      end else if (mem_we) spur++;
      v = $urandom_range(99) >= gap;
      in_valid = v;
      in_data  = v ? s[i] : 8'($urandom);
      restart  = hold_rs;
      if (v) chk("ready", 32'(in_ready), 32'd1);
      @(posedge clk1);
      cyc++;
      pend = 1'b0;
      if (v) begin
        if (!hdr_err && i >= 2 && i < 2 + 4 * n && (i - 2) % 4 == 3) begin
          pend = 1'b1;
          pa = 32'((i - 2) / 4);
          pw = {s[i-3], s[i-2], s[i-1], s[i]};
        end
        i++;
      end
    end
    chk("bytes_taken", 32'(i), 32'(want));
    @(negedge clk1);
    in_valid = 1'b0;
    restart  = 1'b0;
    if (pend) begin
      chk("we", 32'(mem_we), 32'd1);
      chk("addr", 32'(mem_addr), pa);
      chk("wdata", mem_wdata, pw);
    end else if (mem_we) spur++;
    chk("spurious_we", 32'(spur), 32'd0);
    if (stop_at >= nb) begin
      if (hdr_err || s[nb-1] != x) begin
        chk("err_load_err", 32'(load_err), 32'd1);
        chk("err_cpu_run", 32'(cpu_run), 32'd0);
        chk("err_done", 32'(load_done), 32'd0);
        chk("err_ready", 32'(in_ready), 32'd0);
      end else begin
        chk("run_done", 32'(load_done), 32'd1);
        chk("run_cpu_run", 32'(cpu_run), 32'd1);
        chk("run_ready", 32'(in_ready), 32'd0);
        chk("run_err", 32'(load_err), 32'd0);
        @(negedge clk1);
        chk("run_done_pulse", 32'(load_done), 32'd0);
        chk("run_hold", 32'(cpu_run), 32'd1);
        chk("run_no_we", 32'(mem_we), 32'd0);
      end
    end
  endtask

  task automatic do_restart();
    @(negedge clk1);
    restart = 1'b1;
    @(negedge clk1);
    restart = 1'b0;
    chk("rs_ready", 32'(in_ready), 32'd1);
    chk("rs_cpu_run", 32'(cpu_run), 32'd0);
    chk("rs_err", 32'(load_err), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_run"}, 32'(cpu_run), 32'd0);
    chk({tag, "_done"}, 32'(load_done), 32'd0);
    chk({tag, "_err"}, 32'(load_err), 32'd0);
  endtask

  bq_t s1, s1b, s0, sh, sbig, sr;

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    restart = 1'b0;
    s1  = {8'h00, 8'h02, 8'h28, 8'h01, 8'h00, 8'h0a,
           8'hfc, 8'h00, 8'h00, 8'h00, 8'hdf};
    s1b = s1;
    s1b[10] = 8'hde;
    s0  = {8'h00, 8'h00, 8'h00};
    sh  = {8'h04, 8'h01};
    repeat (3) @(negedge clk1);
    chk_reset_vals("rst");
    reset = 1'b0;

    send(s1, 0, 1'b0, 1 << 30);
    do_restart();
    send(s1b, 0, 1'b0, 1 << 30);
    do_restart();
    send(s1, 0, 1'b0, 1 << 30);
    do_restart();
    send(s0, 0, 1'b0, 1 << 30);
    do_restart();
    send(sh, 0, 1'b0, 1 << 30);
    do_restart();
    sbig = make_stream(1024, 1'b0);
    send(sbig, 0, 1'b0, 1 << 30);
    do_restart();
    send(s1, 40, 1'b1, 1 << 30);
    do_restart();

    for (int t = 0; t < 6; t++) begin
      sr = make_stream($urandom_range(1, 8), $urandom_range(0, 2) == 0);
      send(sr, $urandom_range(0, 50), $urandom_range(0, 1) == 1, 1 << 30);
      do_restart();
    end

    send(s1, 0, 1'b0, 6);
    in_valid = 1'b1;
    in_data  = s1[6];
    #2 reset = 1'b1;
    #1 chk_reset_vals("async");
    repeat (2) begin
      @(negedge clk1);
      chk("rst_hold_we", 32'(mem_we), 32'd0);
    end
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk1);
    chk_reset_vals("post_rst");

    sr = make_stream(3, 1'b0);
    send(sr, 20, 1'b0, 1 << 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader sitting directly upstream of the pipelined MIPS-32 core (`Main`). It accepts a byte stream with a valid/ready handshake and assembles big-endian 32-bit instruction words. It writes them into the core's instruction/data memory from word address 0 upward, checks an XOR checksum, and releases the core to run only after a clean load. It replaces the manual preload of memory, PC and HALTED.

## Interface
- `ADDR_W`, default 10: memory word-address width; capacity = 2**ADDR_W words.
- `clk1`  in  1  clock. The loader runs on the first phase only; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  byte on `in_data` is valid.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `restart`  in  1  level; begin a new load. Honoured only in RUN or ERR.
- `mem_we`  out  1  one-cycle memory write strobe.
- `mem_addr`  out  ADDR_W  word address of the write.
- `mem_wdata`  out  32  instruction word.
- `cpu_run`  out  1  high = core released (PC=0, HALTED=0, TAKEN_BRANCH=0). Low = core held.
- `load_done`  out  1  one-cycle pulse on entry to RUN.
- `load_err`  out  1  level, high while in ERR.

## Operation
- Stream format:
  - 16-bit word count N, high byte first.
  - N×4 payload bytes, each word big-endian (byte 0 = bits 31:24).
  - One checksum byte equal to the XOR of all payload bytes. Header bytes are excluded from the checksum.
- A byte is accepted when `in_valid && in_ready` at a rising `clk1` edge.
- States and transitions:
  - HDR_HI: accept a byte → N[15:8]; go to HDR_LO.
  - HDR_LO: accept a byte → N[7:0]. Then:
    - if N > 2**ADDR_W → ERR;
    - else if N == 0 → CSUM;
    - else → DATA.
  - DATA: shift each byte into a 32-bit assembly register; XOR it into the checksum; byte counter counts 0–3.
    - On the 4th byte, register the write (`mem_addr` = word index, `mem_wdata` = assembled word); word index +1.
    - After word N-1 → CSUM.
  - CSUM: accept a byte. Equal to the running XOR → RUN, otherwise → ERR.
  - RUN: `cpu_run`=1; `load_done` pulses for the first cycle only. `restart` → HDR_HI.
  - ERR: `load_err`=1, `cpu_run`=0. `restart` → HDR_HI.
- `in_ready` = 1 in HDR_HI/HDR_LO/DATA/CSUM and 0 in RUN/ERR. It is a combinational decode of state, with no internal stall.
- On `restart` → HDR_HI, clear: byte counter, word index, checksum, assembly register.
- `restart` is ignored in HDR_HI/HDR_LO/DATA/CSUM.
- Memory is never cleared. Words at or above N keep their old contents.
- Arithmetic:
  - Word index is ADDR_W+1 bits wide, so that N = 2**ADDR_W is legal and fills the memory exactly; addresses wrap only via that bound.
  - The comparison to N is 17-bit unsigned.

## Timing
- Reset values:
  - state HDR_HI, so `in_ready`=1;
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0;
  - `cpu_run`=0, `load_done`=0, `load_err`=0;
  - all counters and the checksum cleared.
- Reset asserted mid-load aborts immediately (asynchronously). No further `mem_we`; the partial load is discarded.
- `mem_we` rises the cycle after the edge that accepted the 4th byte of a word. It lasts exactly one cycle, and address/data are stable that cycle.
- Back-to-back bytes at full rate are accepted. The checksum byte may be accepted in the same cycle as the last word's `mem_we`.
- `cpu_run` and `load_done` assert the cycle after the checksum byte is accepted. `load_err` asserts the cycle after an offending header or checksum byte.
- `cpu_run` deasserts the cycle after `restart` is sampled in RUN.
- Gaps in `in_valid` only stretch the load; the result is identical.

## Test plan
- Stream 00 02 28 01 00 0a fc 00 00 00 df at full rate → writes addr0=0x2801000a and addr1=0xfc000000. `load_done` pulse, then `cpu_run`=1, `in_ready`=0, `load_err`=0.
- Same stream with the checksum byte set to 0xde → both writes occur, then `load_err`=1 and `cpu_run` stays 0. Then `restart` plus the correct stream → RUN.
- Stream 00 00 00 (N=0) → no `mem_we`; RUN the cycle after the 3rd byte.
- ADDR_W=10 with header 04 01 → ERR after the 2nd byte, no writes. Header 04 00 → 1024 writes at addresses 0..1023, then the checksum is checked.
- Same stream as the first scenario with random `in_valid` bubbles → identical writes and final state. `restart` held during DATA has no effect.
- `reset` pulsed after 6 accepted bytes → outputs return to their reset values immediately, with no write for the second word. A subsequent clean stream loads correctly.
